// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//   Button sequencer for the 1 kHz stopwatch. It debounces the start and lap
//   buttons, runs the IDLE/RUN/PAUSE/LAP mode FSM, and owns the sub-second
//   millisecond counter that produces the seconds tick for the HH:MM:SS chain.
//
// Parameters
//   DEBOUNCE  : consecutive stable cycles needed to accept a button change
//   LONGPRESS : cycles debounced start must stay high to force a clear
//   TICK_DIV  : running cycles per sec_tick
//
// Ports
//   clk       in   1 kHz system clock, rising edge
//   rst       in   asynchronous active-high reset
//   btn_start in   raw start/stop button (asynchronous, active-high)
//   btn_lap   in   raw lap/clear button (asynchronous, active-high)
//   run       out  time counting enabled (RUN or LAP)
//   sec_tick  out  one-cycle pulse per elapsed running second
//   clr       out  one-cycle pulse clearing the HH:MM:SS counters
//   freeze    out  display holds the lap snapshot
//   state     out  IDLE=0, RUN=1, PAUSE=2, LAP=3
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int DEBOUNCE  = 20,
    parameter int LONGPRESS = 1000,
    parameter int TICK_DIV  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_lap,
    output logic       run,
    output logic       sec_tick,
    output logic       clr,
    output logic       freeze,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int HOLD_W = $clog2(LONGPRESS + 1);
    localparam int MS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [HOLD_W-1:0] HOLD_FULL = HOLD_W'(LONGPRESS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONGPRESS - 1);
    localparam logic [MS_W-1:0]   MS_MAX    = MS_W'(TICK_DIV - 1);

    // Bit 0 = start button, bit 1 = lap button.
    logic [1:0]        btn_raw;
    logic [1:0]        sync_a;
    logic [1:0]        sync_b;
    logic [DB_W-1:0]   db_cnt [2];
    logic [1:0]        deb;
    logic [1:0]        deb_q;
    logic [1:0]        press;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_fire;
    logic              clr_now;
    logic [MS_W-1:0]   ms_cnt;
    state_t            state_q;

    assign btn_raw = {btn_lap, btn_start};
    assign press   = deb & ~deb_q;
    assign state   = state_q;

    // Synchronizer plus debounce counter per button. The counter only runs
    // while the synced level disagrees with the accepted level, so any
    // glitch shorter than DEBOUNCE restarts it without changing deb.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
            deb    <= '0;
            deb_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            deb_q  <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Hold counter saturates at LONGPRESS so the clear fires once per hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (!deb[0]) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_FULL) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign long_fire = deb[0] && (hold_cnt == HOLD_LAST);

    // Clear requested this cycle: long press, or a lap press (with no start
    // press competing) while stopped.
    assign clr_now = long_fire ||
                     (!press[0] && press[1] && (state_q == IDLE || state_q == PAUSE));

    // Mode FSM with registered outputs. Priority: long press > start > lap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            run     <= 1'b0;
            freeze  <= 1'b0;
            clr     <= 1'b0;
        end else begin
            clr <= clr_now;
            if (long_fire) begin
                state_q <= IDLE;
                run     <= 1'b0;
                freeze  <= 1'b0;
            end else if (press[0]) begin
                case (state_q)
                    IDLE:  begin state_q <= RUN;   run <= 1'b1; end
                    RUN:   begin state_q <= PAUSE; run <= 1'b0; end
                    PAUSE: begin state_q <= RUN;   run <= 1'b1; end
                    LAP:   begin state_q <= PAUSE; run <= 1'b0; freeze <= 1'b0; end
                    default: ;
                endcase
            end else if (press[1]) begin
                case (state_q)
                    RUN:   begin state_q <= LAP; freeze <= 1'b1; end
                    LAP:   begin state_q <= RUN; freeze <= 1'b0; end
                    PAUSE: begin state_q <= IDLE; end
                    default: ;
                endcase
            end
        end
    end

    // Millisecond counter. Holds while not running so PAUSE keeps sub-second
    // time; a clear in the same cycle wins over a pending wrap and its tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ms_cnt   <= '0;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            if (clr_now) begin
                ms_cnt <= '0;
            end else if (run) begin
                if (ms_cnt == MS_MAX) begin
                    ms_cnt   <= '0;
                    sec_tick <= 1'b1;
                end else begin
                    ms_cnt <= ms_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_lap = 1'b0;
    logic       run;
    logic       sec_tick;
    logic       clr;
    logic       freeze;
    logic [1:0] state;

    int n_total = 0;
    int n_pass  = 0;
    int tick_cnt = 0;
    int clr_cnt  = 0;
    int clr_snap;

    stopwatch_ctrl #(
        .DEBOUNCE (4),
        .LONGPRESS(16),
        .TICK_DIV (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_start(btn_start),
        .btn_lap  (btn_lap),
        .run      (run),
        .sec_tick (sec_tick),
        .clr      (clr),
        .freeze   (freeze),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (sec_tick === 1'b1) tick_cnt++;
        if (clr === 1'b1) clr_cnt++;
    end

    typedef struct {
        string      name;
        int         n;
        logic       start;
        logic       lap;
        logic [1:0] st;
        logic       run;
        logic       frz;
        logic       clr;
        logic       tick;
    } vec_t;

    vec_t vecs [13];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_outs(input string name, input logic [1:0] st, input logic r,
                              input logic f, input logic c, input logic t);
        check({name, "_state"}, 32'(state), 32'(st));
        check({name, "_run"}, 32'(run), 32'(r));
        check({name, "_freeze"}, 32'(freeze), 32'(f));
        check({name, "_clr"}, 32'(clr), 32'(c));
        check({name, "_tick"}, 32'(sec_tick), 32'(t));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Edge numbers in comments count from the reset release point (edge 0).
        //            name            n  st lap  state run frz clr tick
        vecs[0]  = '{"idle_db",       6, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // e6
        vecs[1]  = '{"start_run",     1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0}; // e7
        vecs[2]  = '{"run_hold",      3, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0}; // e10
        vecs[3]  = '{"first_tick",    7, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1}; // e17
        vecs[4]  = '{"tick_end",      1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0}; // e18
        vecs[5]  = '{"lap_db",        6, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0}; // e24
        vecs[6]  = '{"enter_lap",     1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0}; // e25
        vecs[7]  = '{"lap_tick",      2, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1}; // e27
        vecs[8]  = '{"lap_tick_end",  1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0}; // e28
        vecs[9]  = '{"lap_idle",      4, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0}; // e32
        vecs[10] = '{"lap2_db",       6, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0}; // e38
        vecs[11] = '{"exit_lap",      1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0}; // e39
        vecs[12] = '{"run_tick",      8, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1}; // e47

        // Reset state.
        step(3);
        check_outs("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_ms", 32'(dut.ms_cnt), 32'd0);
        rst = 1'b0;

        // Start, first ticks and lap enter/exit.
        foreach (vecs[i]) begin
            btn_start = vecs[i].start;
            btn_lap   = vecs[i].lap;
            step(vecs[i].n);
            check_outs(vecs[i].name, vecs[i].st, vecs[i].run, vecs[i].frz,
                       vecs[i].clr, vecs[i].tick);
        end
        check("ticks_upto_e46", 32'(tick_cnt), 32'd3);      // e17, e27, e37

        // Start bursts of 3 high / 1 low never qualify: edges 48..67.
        for (int i = 0; i < 20; i++) begin
            btn_start = ((i % 4) != 3);
            step(1);
            check("burst_state", 32'(state), 32'd1);
            check("burst_run", 32'(run), 32'd1);
        end
        btn_start = 1'b0;
        step(1);                                             // e68
        check("ticks_upto_e67", 32'(tick_cnt), 32'd6);       // + e47, e57, e67

        // Pause with 5 ms pending, then resume and expect a short second.
        step(7);                                             // e75
        btn_start = 1'b1;
        step(6);                                             // e81
        check("pre_pause_state", 32'(state), 32'd1);
        btn_start = 1'b0;
        step(1);                                             // e82
        check_outs("pause", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(3);                                             // e85
        check("pause_ms_held", 32'(dut.ms_cnt), 32'd5);
        check("ticks_upto_e84", 32'(tick_cnt), 32'd7);       // + e77
        step(5);                                             // e90
        btn_start = 1'b1;
        step(6);                                             // e96
        check("still_paused", 32'(state), 32'd2);
        step(1);                                             // e97
        check_outs("resume", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        btn_start = 1'b0;
        step(4);                                             // e101
        check("resume_ms", 32'(dut.ms_cnt), 32'd9);
        check("resume_no_tick", 32'(sec_tick), 32'd0);
        step(1);                                             // e102
        check("resume_short_tick", 32'(sec_tick), 32'd1);

        // Pause again, then lap clears to IDLE.
        step(2);                                             // e104
        btn_start = 1'b1;
        step(6);                                             // e110
        btn_start = 1'b0;
        step(1);                                             // e111
        check_outs("pause2", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(6);                                             // e117
        btn_lap = 1'b1;
        step(6);                                             // e123
        check("pre_clear_state", 32'(state), 32'd2);
        check("pre_clear_clr", 32'(clr), 32'd0);
        step(1);                                             // e124
        check_outs("pause_lap_clr", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("clear_ms", 32'(dut.ms_cnt), 32'd0);
        check("ticks_upto_e123", 32'(tick_cnt), 32'd8);      // + e102 only
        btn_lap = 1'b0;
        step(1);                                             // e125
        check("clr_one_cycle", 32'(clr), 32'd0);

        // Long press from IDLE: S = e132.
        step(7);                                             // e132
        btn_start = 1'b1;
        step(6);                                             // S+6
        check("lp_idle", 32'(state), 32'd0);
        step(1);                                             // S+7
        check_outs("lp_run", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(14);                                            // S+21
        check("lp_pre_state", 32'(state), 32'd1);
        check("lp_pre_clr", 32'(clr), 32'd0);
        step(1);                                             // S+22
        check_outs("lp_clr", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("lp_ms", 32'(dut.ms_cnt), 32'd0);
        step(1);                                             // S+23
        check("lp_clr_end", 32'(clr), 32'd0);
        clr_snap = clr_cnt;
        step(7);                                             // S+30
        btn_start = 1'b0;
        step(10);                                            // S+40
        check("lp_no_second_clr", 32'(clr_cnt - clr_snap), 32'd0);
        check("lp_stay_idle", 32'(state), 32'd0);

        // Reset mid-RUN with lap held: T = e174.
        step(2);
        btn_start = 1'b1;
        step(6);
        btn_start = 1'b0;
        step(1);
        check("rst_pre_run", 32'(state), 32'd1);
        step(2);
        btn_lap = 1'b1;
        step(2);
        rst = 1'b1;
        #1;
        check_outs("async_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        rst = 1'b0;
        step(6);
        check("requal_state", 32'(state), 32'd0);
        check("requal_clr", 32'(clr), 32'd0);
        step(1);
        check_outs("requal_lap_clr", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        btn_lap = 1'b0;
        step(1);
        check("requal_clr_end", 32'(clr), 32'd0);
        check("requal_idle", 32'(state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Button-driven sequencer for the 1 kHz stopwatch datapath: it debounces the start and lap push-buttons, runs the IDLE/RUN/PAUSE/LAP mode FSM, and owns the sub-second millisecond counter. It drives the count-enable, a one-cycle seconds tick, a clear pulse and a display-freeze (lap hold) to the HH:MM:SS counters and the 7-segment scan logic. It sits between the raw board buttons and the time-counter chain, so the counter chain only advances on `sec_tick`.

## Interface
- `DEBOUNCE`, 20: consecutive stable cycles (ms) required to accept a button level change.
- `LONGPRESS`, 1000: cycles the debounced start button must stay high to force a clear.
- `TICK_DIV`, 1000: running cycles per `sec_tick`.
- `clk`  in  1  1 kHz system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_start`  in  1  raw start/stop button, asynchronous, active-high.
- `btn_lap`  in  1  raw lap/clear button, asynchronous, active-high.
- `run`  out  1  time counting enabled.
- `sec_tick`  out  1  one-cycle pulse per elapsed running second.
- `clr`  out  1  one-cycle pulse: clear HH:MM:SS counters.
- `freeze`  out  1  display holds the lap snapshot; counters keep running.
- `state`  out  2  IDLE=0, RUN=1, PAUSE=2, LAP=3.

## Operation
- Each button: 2-FF synchronizer -> debounce counter. The counter resets to 0 whenever the synced level equals the debounced level. It increments while they differ. At `DEBOUNCE` the debounced level takes the synced level and the counter clears. A glitch shorter than `DEBOUNCE` restarts the count and never changes the debounced level.
- Press event = debounced rising edge (debounced high, previous debounced low), one cycle wide. Releases generate no events.
- FSM transitions (all other event/state combinations hold state):
  - IDLE + start -> RUN.
  - RUN + start -> PAUSE.
  - PAUSE + start -> RUN.
  - RUN + lap -> LAP, `freeze`=1.
  - LAP + lap -> RUN, `freeze`=0.
  - LAP + start -> PAUSE, `freeze`=0.
  - PAUSE + lap -> IDLE with a `clr` pulse.
  - IDLE + lap -> IDLE with a `clr` pulse.
- Long press: a hold counter increments while debounced start is high and resets when it is low. Reaching `LONGPRESS` fires `clr` once per hold, forces IDLE and drops `freeze`. The press edge that began the hold has already toggled the state; that toggle is accepted.
- Priority for simultaneous events in one cycle: long-press clear > start > lap.
- `run` = 1 in RUN and LAP, 0 in IDLE and PAUSE. All outputs are registered and change on the same edge as `state`.
- `ms_cnt` (clog2(`TICK_DIV`) bits):
  - Increments only when `run`=1.
  - When it equals `TICK_DIV`-1 with `run`=1, it wraps to 0 and `sec_tick`=1 on the following cycle.
  - PAUSE holds `ms_cnt`, so sub-second time is preserved.
  - Any `clr` zeroes `ms_cnt` on the same edge. A pending wrap in that cycle is discarded: no `sec_tick`.

## Timing
- Reset values: `run`=0, `sec_tick`=0, `clr`=0, `freeze`=0, `state`=IDLE. Synchronizers, debounce/hold counters and `ms_cnt` are all 0.
- Reset mid-debounce or mid-hold discards the partial count. A button still held after reset release must re-qualify. Because debounced=0 after reset, a held button produces one press event after `DEBOUNCE`+2 edges.
- Press latency: counting from the first edge sampling raw high (edge 1), with the input stable:
  - edge 2: synced;
  - edge `DEBOUNCE`+2: debounced level high;
  - edge `DEBOUNCE`+3: FSM and outputs update.
- Long-press `clr` edge: `LONGPRESS` edges after the debounced level rises.
- `sec_tick` period: exactly `TICK_DIV` running cycles. The first tick after IDLE->RUN comes `TICK_DIV` cycles after `run` rises.
- `clr` is high for exactly one cycle; `sec_tick` is high for exactly one cycle.

## Test plan
Bench parameters: `DEBOUNCE`=4, `LONGPRESS`=16, `TICK_DIV`=10.
- Reset, then hold `btn_start` high 10 cycles -> `state` 0->1 and `run`=1 at edge 7. `sec_tick` pulses every 10 cycles thereafter: 3 pulses in 30 cycles.
- While running, apply `btn_start` bursts of 3-cycle highs and 1-cycle lows for 20 cycles -> no state change, `run` stays 1.
- RUN, press lap -> `state`=3, `freeze`=1, `sec_tick` continues. Press lap again -> `state`=1, `freeze`=0.
- RUN for 25 cycles, press start -> PAUSE, `ms_cnt` held at 5 (plus debounce cycles). Resume -> the next `sec_tick` comes after the remaining count, not a full 10. Pause, then lap -> `clr` for 1 cycle, `state`=0, `ms_cnt`=0.
- From IDLE, hold start 30 cycles -> RUN at edge 7; `clr` pulse and `state`=0 at edge 22; no second `clr` before release.
- Assert `rst` mid-RUN with `btn_lap` held -> all outputs 0 immediately. After release, lap qualifies after 6 edges as an IDLE+lap: one `clr` pulse, state stays 0.
